stack_engine: RTL and testbench
===============================

# stack_engine

Command consumer for the stack calculator. Takes the one-cycle command code produced by the button-decode stage plus the 8-bit switch operand. Executes push/pop/add/sub/top/reset/inc/dec against an internal RAM stack. Drives the display value, display address and status flags for the seven-segment/LED stage.

## Interface
Parameters:
- WIDTH, 8, data word width
- DEPTH, 16, stack entries (power of two)
- AW, 4, log2(DEPTH)

Ports:
- iClk  in  1  system clock
- iRst  in  1  reset; synchronous, active-high
- iCmd  in  4  command code, one-cycle pulse, 0 = idle
- iData  in  WIDTH  push operand (switches)
- oDisp  out  WIDTH  registered contents of mem[DAR]
- oDispAddr  out  AW  display address register (DAR)
- oCount  out  AW+1  entries on stack, 0..DEPTH
- oEmpty  out  1  oCount == 0
- oFull  out  1  oCount == DEPTH
- oBusy  out  1  FSM not in IDLE
- oErr  out  1  one-cycle pulse on a rejected command

## Operation
- Command codes: 0 idle, 1 PSH, 2 POP, 3 ADD, 4 SUB, 5 TOP, 6 RST, 7 INC, 8 DEC.
- Codes 9–15 are ignored, with no error.
- iCmd is sampled only in IDLE. Commands arriving while oBusy=1 are dropped silently.
- FSM states: IDLE, PSH_WR, RD_B, RD_A, ALU_WR, REFRESH.
- PSH:
  - Rejected with oErr if oFull.
  - Otherwise latch iData, then mem[cnt]←operand, cnt++, DAR←old cnt.
- POP:
  - Rejected with oErr if oEmpty.
  - Otherwise cnt--, DAR←(old cnt ≥ 2 ? old cnt−2 : 0).
  - Memory is not modified.
- ADD/SUB:
  - Rejected with oErr if cnt < 2.
  - B←mem[cnt−1] (top), A←mem[cnt−2].
  - mem[cnt−2]←A+B or A−B, modulo 2^WIDTH, no carry or borrow flag.
  - cnt--, DAR←cnt_new−1.
- TOP: DAR←(cnt ? cnt−1 : 0).
- RST: cnt←0, DAR←0. Memory contents are retained.
- INC/DEC: DAR ±1 modulo DEPTH. Allowed at any count, including empty.
- oErr is never asserted for TOP, RST, INC or DEC.
- oDisp always reflects mem[DAR] as of the last REFRESH. DAR beyond the stack top shows stale RAM contents; this is permitted.

## Timing
Command sampled at edge N.
- PSH: edge N+1 writes RAM. Edge N+2 updates oDisp. oBusy high 2 cycles.
- ADD/SUB: RD_B at N+1, RD_A at N+2, ALU_WR write at N+3, REFRESH at N+4. oBusy high 4 cycles.
- POP/TOP/RST/INC/DEC: registers update at edge N, oDisp at N+1. oBusy high 1 cycle.
- Rejected command: oErr high for the single cycle after edge N. State stays IDLE.
- oCount, oEmpty and oFull change on the edge where cnt is written.
- Reset values: oDisp=0, oDispAddr=0, oCount=0, oEmpty=1, oFull=0, oBusy=0, oErr=0, state=IDLE.
- Reset mid-operation:
  - Aborts immediately; the pending RAM write does not occur.
  - RAM contents are not cleared.
  - Reset has priority over any same-cycle iCmd.
- RAM is single-port with synchronous read (1-cycle latency). The address is muxed by state: write address in PSH_WR/ALU_WR, operand address in RD_*, DAR in REFRESH.

## Structure
- Package calc_pkg holds:
  - command code constants CMD_IDLE..CMD_DEC (shared with the button-decode stage);
  - the FSM state enum;
  - default WIDTH/DEPTH.
- Sub-module stack_ram holds the DEPTH×WIDTH single-port RAM: synchronous write enable, registered read.
- FSM, cnt/DAR registers, operand registers and the ALU live in stack_engine.

## Test plan
- Reset, then PSH 0x05 and PSH 0x07, then ADD → oDisp=0x0C, oCount=1, oDispAddr=0, oBusy high exactly 4 cycles for the ADD.
- PSH 0x03, PSH 0x05, SUB → oDisp=0xFE (wrap), oCount=1.
- 16 pushes → oFull=1. 17th PSH → oErr pulse for 1 cycle, oCount stays 16, mem unchanged.
- POP on empty → oErr pulse. ADD with one entry → oErr, oCount=1.
- DAR=15, INC → oDispAddr=0. DEC → 15. No oErr.
- iRst asserted during RD_A of an ADD → next cycle oCount=0, IDLE. A following TOP after re-pushes shows the unmodified original operands.

Source files
------------

// File: rtl/calc_pkg.sv
// Shared definitions for the stack calculator: command codes, engine FSM states
// and default datapath sizing.
package calc_pkg;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_DEPTH = 16;

  localparam logic [3:0] CMD_IDLE = 4'd0;
  localparam logic [3:0] CMD_PSH  = 4'd1;
  localparam logic [3:0] CMD_POP  = 4'd2;
  localparam logic [3:0] CMD_ADD  = 4'd3;
  localparam logic [3:0] CMD_SUB  = 4'd4;
  localparam logic [3:0] CMD_TOP  = 4'd5;
  localparam logic [3:0] CMD_RST  = 4'd6;
  localparam logic [3:0] CMD_INC  = 4'd7;
  localparam logic [3:0] CMD_DEC  = 4'd8;

  typedef enum logic [2:0] {
    IDLE,
    PSH_WR,
    RD_B,
    RD_A,
    ALU_WR,
    REFRESH
  } state_e;

endpackage

// File: rtl/stack_engine_if.sv
// Command/display bundle between the button-decode stage, the stack engine
// and the seven-segment/LED stage.
interface stack_engine_if #(
  parameter int WIDTH = 8,
  parameter int AW    = 4
);
  logic [3:0]       iCmd;
  logic [WIDTH-1:0] iData;
  logic [WIDTH-1:0] oDisp;
  logic [AW-1:0]    oDispAddr;
  logic [AW:0]      oCount;
  logic             oEmpty;
  logic             oFull;
  logic             oBusy;
  logic             oErr;

  modport master (
    output iCmd, iData,
    input  oDisp, oDispAddr, oCount, oEmpty, oFull, oBusy, oErr
  );

  modport slave (
    input  iCmd, iData,
    output oDisp, oDispAddr, oCount, oEmpty, oFull, oBusy, oErr
  );
endinterface

// File: rtl/stack_ram.sv
// Single-port stack RAM with synchronous write and registered read. One address
// port feeds two capture registers: the display latch and the ALU operand latch.
module stack_ram #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             we_i,
  input  logic [AW-1:0]    addr_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             disp_en_i,
  input  logic             opnd_en_i,
  output logic [WIDTH-1:0] disp_o,
  output logic [WIDTH-1:0] opnd_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] disp_q;
  logic [WIDTH-1:0] opnd_q;

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[addr_i] <= wdata_i;
    end
  end

  // Display latch holds its value between refreshes so operand reads never leak out.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      disp_q <= '0;
    end else if (disp_en_i) begin
      disp_q <= mem_q[addr_i];
    end
  end

  always_ff @(posedge clk_i) begin
    if (opnd_en_i) begin
      opnd_q <= mem_q[addr_i];
    end
  end

  assign disp_o = disp_q;
  assign opnd_o = opnd_q;

endmodule

// File: rtl/stack_engine.sv
// Stack calculator command consumer: executes push/pop/add/sub/top/reset/inc/dec
// against a RAM-backed stack and drives display value, address and status flags.
module stack_engine
  import calc_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          iClk,
  input  logic          iRst,
  stack_engine_if.slave bus
);

  localparam logic [AW:0] CNT_ONE  = (AW+1)'(1);
  localparam logic [AW:0] CNT_TWO  = (AW+1)'(2);
  localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);

  state_e           state_q;
  logic [AW:0]      cnt_q;
  logic [AW-1:0]    dar_q;
  logic             err_q;
  logic [WIDTH-1:0] opnd_q;
  logic             sub_q;

  logic [AW-1:0]    cnt_lo, top_addr, below_addr;
  logic             full, empty, two_plus;

  logic             ram_we, disp_en, opnd_en;
  logic [AW-1:0]    ram_addr;
  logic [WIDTH-1:0] ram_wdata, ram_disp, ram_opnd;

  function automatic logic [WIDTH-1:0] alu_result(input logic [WIDTH-1:0] a,
                                                  input logic [WIDTH-1:0] b,
                                                  input logic             sub);
    return sub ? (a - b) : (a + b);
  endfunction

  // With cnt == DEPTH the low bits wrap to 0, so cnt_lo - 1 still names the top slot.
  assign cnt_lo     = cnt_q[AW-1:0];
  assign top_addr   = cnt_lo - AW'(1);
  assign below_addr = cnt_lo - AW'(2);
  assign full       = (cnt_q == CNT_FULL);
  assign empty      = (cnt_q == '0);
  assign two_plus   = (cnt_q >= CNT_TWO);

  always_ff @(posedge iClk) begin
    if (iRst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      dar_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      err_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          case (bus.iCmd)
            CMD_PSH: begin
              if (full) err_q <= 1'b1;
              else      state_q <= PSH_WR;
            end
            CMD_POP: begin
              if (empty) begin
                err_q <= 1'b1;
              end else begin
                cnt_q   <= cnt_q - CNT_ONE;
                dar_q   <= two_plus ? below_addr : '0;
                state_q <= REFRESH;
              end
            end
            CMD_ADD, CMD_SUB: begin
              if (!two_plus) err_q <= 1'b1;
              else           state_q <= RD_B;
            end
            CMD_TOP: begin
              dar_q   <= empty ? '0 : top_addr;
              state_q <= REFRESH;
            end
            CMD_RST: begin
              cnt_q   <= '0;
              dar_q   <= '0;
              state_q <= REFRESH;
            end
            CMD_INC: begin
              dar_q   <= dar_q + AW'(1);
              state_q <= REFRESH;
            end
            CMD_DEC: begin
              dar_q   <= dar_q - AW'(1);
              state_q <= REFRESH;
            end
            default: ;
          endcase
        end
        PSH_WR: begin
          cnt_q   <= cnt_q + CNT_ONE;
          dar_q   <= cnt_lo;
          state_q <= REFRESH;
        end
        RD_B:    state_q <= RD_A;
        RD_A:    state_q <= ALU_WR;
        ALU_WR: begin
          cnt_q   <= cnt_q - CNT_ONE;
          dar_q   <= below_addr;
          state_q <= REFRESH;
        end
        REFRESH: state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  // Operand register: push value in IDLE, then reused to hold B while A is read.
  always_ff @(posedge iClk) begin
    if (state_q == IDLE) begin
      opnd_q <= bus.iData;
      sub_q  <= (bus.iCmd == CMD_SUB);
    end else if (state_q == RD_A) begin
      opnd_q <= ram_opnd;
    end
  end

  always_comb begin
    ram_addr  = dar_q;
    ram_we    = 1'b0;
    ram_wdata = opnd_q;
    disp_en   = 1'b0;
    opnd_en   = 1'b0;
    unique case (state_q)
      PSH_WR: begin
        ram_addr = cnt_lo;
        ram_we   = !iRst;
      end
      RD_B: begin
        ram_addr = top_addr;
        opnd_en  = 1'b1;
      end
      RD_A: begin
        ram_addr = below_addr;
        opnd_en  = 1'b1;
      end
      ALU_WR: begin
        ram_addr  = below_addr;
        ram_we    = !iRst;
        ram_wdata = alu_result(ram_opnd, opnd_q, sub_q);
      end
      REFRESH: disp_en = 1'b1;
      default: ;
    endcase
  end

  stack_ram #(
    .WIDTH(WIDTH),
    .DEPTH(DEPTH),
    .AW   (AW)
  ) u_ram (
    .clk_i    (iClk),
    .rst_i    (iRst),
    .we_i     (ram_we),
    .addr_i   (ram_addr),
    .wdata_i  (ram_wdata),
    .disp_en_i(disp_en),
    .opnd_en_i(opnd_en),
    .disp_o   (ram_disp),
    .opnd_o   (ram_opnd)
  );

  assign bus.oDisp     = ram_disp;
  assign bus.oDispAddr = dar_q;
  assign bus.oCount    = cnt_q;
  assign bus.oEmpty    = empty;
  assign bus.oFull     = full;
  assign bus.oBusy     = (state_q != IDLE);
  assign bus.oErr      = err_q;

endmodule

// File: tb/tb_stack_engine.sv
// Bench for stack_engine: directed scenarios with literal expectations plus
// randomized commands checked every cycle against a transaction-level stack model.
module tb_stack_engine;
  import calc_pkg::*;

  localparam int WIDTH = 8;
  localparam int DEPTH = 16;
  localparam int AW    = 4;

  logic iClk = 1'b0;
  logic iRst;

  stack_engine_if #(.WIDTH(WIDTH), .AW(AW)) bus ();

  stack_engine #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AW(AW)) dut (
    .iClk(iClk),
    .iRst(iRst),
    .bus (bus)
  );

  always #5 iClk = ~iClk;

  int   n_chk = 0;
  int   n_err = 0;
  logic chk_en = 1'b0;

  // Model: stack contents and observable registers, plus one pending effect.
  logic [7:0] m_mem [DEPTH];
  int         m_cnt, m_dar, m_busy;
  logic [7:0] m_disp;
  logic       m_err;
  int         p_reg_t, p_disp_t, p_cnt, p_dar, p_waddr;
  logic       p_wr;
  logic [7:0] p_wdata;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic apply_regs();
    if (p_wr) m_mem[p_waddr] = p_wdata;
    m_cnt = p_cnt;
    m_dar = p_dar;
  endtask

  task automatic schedule(input int cnt, input int dar, input logic wr, input int waddr,
                          input logic [7:0] wdata, input int dreg, input int ddisp,
                          input int busy);
    p_cnt = cnt; p_dar = dar; p_wr = wr; p_waddr = waddr; p_wdata = wdata;
    p_reg_t = dreg;
    if (dreg == 0) apply_regs();
    p_disp_t = ddisp;
    m_busy   = busy;
  endtask

  task automatic model_step(input logic [3:0] c, input logic [7:0] d, input logic r);
    logic       idle;
    logic [7:0] a, b, res;
    if (r) begin
      m_cnt = 0; m_dar = 0; m_disp = 8'h00; m_busy = 0; m_err = 1'b0;
      p_reg_t = 0; p_disp_t = 0;
      return;
    end
    m_err = 1'b0;
    if (p_reg_t > 0) begin
      p_reg_t--;
      if (p_reg_t == 0) apply_regs();
    end
    if (p_disp_t > 0) begin
      p_disp_t--;
      if (p_disp_t == 0) m_disp = m_mem[m_dar];
    end
    idle = (m_busy == 0);
    if (m_busy > 0) m_busy--;
    if (idle) begin
      case (c)
        CMD_PSH: if (m_cnt == DEPTH) m_err = 1'b1;
                 else schedule(m_cnt + 1, m_cnt, 1'b1, m_cnt, d, 1, 2, 2);
        CMD_POP: if (m_cnt == 0) m_err = 1'b1;
                 else schedule(m_cnt - 1, (m_cnt >= 2) ? m_cnt - 2 : 0, 1'b0, 0, 8'h00, 0, 1, 1);
        CMD_ADD, CMD_SUB: begin
          if (m_cnt < 2) m_err = 1'b1;
          else begin
            a = m_mem[m_cnt - 2];
            b = m_mem[m_cnt - 1];
            res = (c == CMD_ADD) ? a + b : a - b;
            schedule(m_cnt - 1, m_cnt - 2, 1'b1, m_cnt - 2, res, 3, 4, 4);
          end
        end
        CMD_TOP: schedule(m_cnt, (m_cnt != 0) ? m_cnt - 1 : 0, 1'b0, 0, 8'h00, 0, 1, 1);
        CMD_RST: schedule(0, 0, 1'b0, 0, 8'h00, 0, 1, 1);
        CMD_INC: schedule(m_cnt, (m_dar + 1) % DEPTH, 1'b0, 0, 8'h00, 0, 1, 1);
        CMD_DEC: schedule(m_cnt, (m_dar + DEPTH - 1) % DEPTH, 1'b0, 0, 8'h00, 0, 1, 1);
        default: ;
      endcase
    end
  endtask

  always @(negedge iClk) begin
    if (chk_en) begin
      check("disp",  32'(bus.oDisp),     32'(m_disp));
      check("addr",  32'(bus.oDispAddr), m_dar);
      check("count", 32'(bus.oCount),    m_cnt);
      check("empty", 32'(bus.oEmpty),    32'(m_cnt == 0));
      check("full",  32'(bus.oFull),     32'(m_cnt == DEPTH));
      check("busy",  32'(bus.oBusy),     32'(m_busy > 0));
      check("err",   32'(bus.oErr),      32'(m_err));
    end
  end

  task automatic tick(input logic [3:0] c, input logic [7:0] d, input logic r);
    bus.iCmd  = c;
    bus.iData = d;
    iRst      = r;
    @(posedge iClk);
    model_step(c, d, r);
    #1;
    bus.iCmd = CMD_IDLE;
    iRst     = 1'b0;
  endtask

  task automatic do_cmd(input logic [3:0] c, input logic [7:0] d);
    int n;
    tick(c, d, 1'b0);
    n = 0;
    while (bus.oBusy !== 1'b0 && n < 10) begin
      tick(CMD_IDLE, 8'h00, 1'b0);
      n++;
    end
    if (n >= 10) begin
      n_chk++;
      n_err++;
      $display("FAIL busy_timeout: busy still %b after %0d cycles, required 0", bus.oBusy, n);
    end
  endtask

  initial begin
    int         nb;
    logic [3:0] c;
    logic       r;
    int         sel;

    bus.iCmd = CMD_IDLE; bus.iData = 8'h00; iRst = 1'b1;
    tick(CMD_IDLE, 8'h00, 1'b1);
    tick(CMD_IDLE, 8'h00, 1'b1);
    chk_en = 1'b1;
    check("lit_rst_disp",  32'(bus.oDisp), 0);
    check("lit_rst_addr",  32'(bus.oDispAddr), 0);
    check("lit_rst_count", 32'(bus.oCount), 0);
    check("lit_rst_empty", 32'(bus.oEmpty), 1);
    check("lit_rst_full",  32'(bus.oFull), 0);
    check("lit_rst_busy",  32'(bus.oBusy), 0);
    check("lit_rst_err",   32'(bus.oErr), 0);

    do_cmd(CMD_PSH, 8'h05);
    do_cmd(CMD_PSH, 8'h07);
    tick(CMD_ADD, 8'h00, 1'b0);
    nb = 0;
    while (bus.oBusy === 1'b1 && nb < 10) begin
      nb++;
      tick(CMD_IDLE, 8'h00, 1'b0);
    end
    check("lit_add_busy_cycles", nb, 4);
    check("lit_add_disp",  32'(bus.oDisp), 32'h0C);
    check("lit_add_count", 32'(bus.oCount), 1);
    check("lit_add_addr",  32'(bus.oDispAddr), 0);

    do_cmd(CMD_RST, 8'h00);
    do_cmd(CMD_PSH, 8'h03);
    do_cmd(CMD_PSH, 8'h05);
    do_cmd(CMD_SUB, 8'h00);
    check("lit_sub_disp",  32'(bus.oDisp), 32'hFE);
    check("lit_sub_count", 32'(bus.oCount), 1);

    do_cmd(CMD_RST, 8'h00);
    for (int i = 0; i < DEPTH; i++) do_cmd(CMD_PSH, 8'(8'h10 + i));
    check("lit_full", 32'(bus.oFull), 1);
    tick(CMD_PSH, 8'hAA, 1'b0);
    check("lit_over_err",   32'(bus.oErr), 1);
    check("lit_over_count", 32'(bus.oCount), 16);
    tick(CMD_IDLE, 8'h00, 1'b0);
    check("lit_over_err_clr", 32'(bus.oErr), 0);
    do_cmd(CMD_TOP, 8'h00);
    check("lit_over_top", 32'(bus.oDisp), 32'h1F);

    do_cmd(CMD_RST, 8'h00);
    tick(CMD_POP, 8'h00, 1'b0);
    check("lit_pop_empty_err", 32'(bus.oErr), 1);
    tick(CMD_IDLE, 8'h00, 1'b0);
    do_cmd(CMD_PSH, 8'h09);
    tick(CMD_ADD, 8'h00, 1'b0);
    check("lit_add_one_err",   32'(bus.oErr), 1);
    check("lit_add_one_count", 32'(bus.oCount), 1);
    tick(CMD_IDLE, 8'h00, 1'b0);

    do_cmd(CMD_RST, 8'h00);
    do_cmd(CMD_DEC, 8'h00);
    check("lit_dec_wrap", 32'(bus.oDispAddr), 15);
    check("lit_dec_err",  32'(bus.oErr), 0);
    do_cmd(CMD_INC, 8'h00);
    check("lit_inc_wrap", 32'(bus.oDispAddr), 0);

    do_cmd(CMD_RST, 8'h00);
    do_cmd(CMD_PSH, 8'h21);
    do_cmd(CMD_PSH, 8'h42);
    tick(CMD_ADD, 8'h00, 1'b0);
    tick(CMD_IDLE, 8'h00, 1'b0);
    tick(CMD_IDLE, 8'h00, 1'b1);
    check("lit_abort_count", 32'(bus.oCount), 0);
    check("lit_abort_busy",  32'(bus.oBusy), 0);
    do_cmd(CMD_INC, 8'h00);
    check("lit_abort_b", 32'(bus.oDisp), 32'h42);
    do_cmd(CMD_DEC, 8'h00);
    check("lit_abort_a", 32'(bus.oDisp), 32'h21);

    for (int i = 0; i < 3000; i++) begin
      r   = ($urandom_range(0, 199) == 0);
      sel = $urandom_range(0, 19);
      if      (sel < 4)  c = CMD_IDLE;
      else if (sel < 9)  c = CMD_PSH;
      else if (sel < 11) c = CMD_POP;
      else if (sel < 13) c = CMD_ADD;
      else if (sel < 15) c = CMD_SUB;
      else if (sel == 15) c = CMD_TOP;
      else if (sel == 16) c = CMD_INC;
      else if (sel == 17) c = CMD_DEC;
      else if (sel == 18) c = 4'($urandom_range(9, 15));
      else c = ($urandom_range(0, 3) == 0) ? CMD_RST : CMD_IDLE;
      tick(c, 8'($urandom), r);
    end

    @(negedge iClk);
    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
